// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential imem reads under a credit limit and
// queues returned words with their PCs for decode; supports run/halt and redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH     = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  input  logic        halt_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  output logic        running_o,
  output logic        fault_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} exec_state_t;

  exec_state_t      state, state_next;
  logic             fault, fault_next;
  logic [31:0]      fetch_pc, rsp_pc;
  logic [OUT_W-1:0] outstanding, discard;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [31:0]      q_data [QUEUE_DEPTH];
  logic [31:0]      q_pc   [QUEUE_DEPTH];

  logic        misaligned, redirect_ok;
  logic        req_fire, push, pop;
  logic [31:0] live, credit_used;

  assign misaligned  = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign redirect_ok = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);

  // Requests whose responses will be kept still need a queue slot reserved.
  assign live        = 32'(outstanding) - 32'(discard);
  assign credit_used = live + 32'(count);

  assign imem_req_valid_o = (state == RUNNING) && !redirect_valid_i &&
                            (credit_used < 32'(QUEUE_DEPTH)) &&
                            (32'(outstanding) < 32'(MAX_OUTSTANDING));
  assign imem_req_addr_o  = fetch_pc;

  assign req_fire = imem_req_valid_o && imem_req_ready_i;
  assign push     = imem_rsp_valid_i && (discard == '0) && !redirect_valid_i;
  assign pop      = inst_valid_o && inst_ready_i;

  assign inst_valid_o = (count != '0);
  assign inst_o       = inst_valid_o ? q_data[rd_ptr] : '0;
  assign inst_pc_o    = inst_valid_o ? q_pc[rd_ptr]   : '0;
  assign running_o    = (state == RUNNING);
  assign fault_o      = fault;

  always_comb begin
    state_next = state;
    fault_next = fault;
    case (state)
      STOPPED: if (run_i && !halt_i) begin
        if (fault) fault_next = 1'b0;
        else       state_next = RUNNING;
      end
      RUNNING: if (halt_i) state_next = STOPPED;
      default: state_next = STOPPED;
    endcase
    if (misaligned) begin
      fault_next = 1'b1;
      state_next = STOPPED;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= STOPPED;
      fault       <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      state       <= state_next;
      fault       <= fault_next;
      outstanding <= outstanding + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid_i);

      // Everything still in flight at a redirect is stale, including a word landing now.
      if (redirect_valid_i)
        discard <= outstanding - OUT_W'(imem_rsp_valid_i);
      else if (imem_rsp_valid_i && (discard != '0))
        discard <= discard - OUT_W'(1);

      if (redirect_ok)   fetch_pc <= redirect_pc_i;
      else if (req_fire) fetch_pc <= fetch_pc + 32'd4;

      if (redirect_ok) rsp_pc <= redirect_pc_i;
      else if (push)   rsp_pc <= rsp_pc + 32'd4;

      if (redirect_valid_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rsp_data_i;
      q_pc[wr_ptr]   <= rsp_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CNT_W'(QUEUE_DEPTH))));

endmodule
